// File: rtl/serial_adder_seq_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_seq_fa_cell.sv
// Full-adder cell: two half-adder stages whose carries are merged by an OR gate.
module fa_cell (
   output logic s_out,
   output logic c_out,
   input  logic a_in,
   input  logic b_in,
   input  logic c_in
);

   logic w_hs0;
   logic w_hc0;
   logic w_hc1;

   assign w_hs0 = a_in ^ b_in;
   assign w_hc0 = a_in & b_in;
   assign s_out = w_hs0 ^ c_in;
   assign w_hc1 = w_hs0 & c_in;
   assign c_out = w_hc0 | w_hc1;

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder, LSB first through one full-adder cell with a registered carry.
// Define SERIAL_ADD_CIN_EN to add a carry-in port (cin_in) that seeds the carry flop.
module serial_adder_seq
   import serial_adder_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
`ifdef SERIAL_ADD_CIN_EN
   input  logic             cin_in,
`endif
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] sum_out,
   output logic             c_out
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t             r_state;
   state_t             w_state_nx;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic               w_cin;
   logic               w_accept;
   logic               w_last;
   logic               w_fa_s;
   logic               w_fa_c;
   logic [WIDTH-1:0]   w_sum_nx;

`ifdef SERIAL_ADD_CIN_EN
   assign w_cin = cin_in;
`else
   assign w_cin = 1'b0;
`endif

   fa_cell u_fa (
      .s_out (w_fa_s),
      .c_out (w_fa_c),
      .a_in  (r_a[0]),
      .b_in  (r_b[0]),
      .c_in  (r_carry)
   );

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special slice.
   always_comb begin
      w_sum_nx            = r_sum >> 1;
      w_sum_nx[WIDTH-1]   = w_fa_s;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) r_state <= ST_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      busy_out   = 1'b0;
      done_out   = 1'b0;
      w_accept   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_in) begin
               w_accept   = 1'b1;
               w_state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            busy_out = 1'b1;
            if (w_last) w_state_nx = ST_DONE;
         end
         ST_DONE: begin
            busy_out   = 1'b1;
            done_out   = 1'b1;
            w_state_nx = ST_IDLE;
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         sum_out <= '0;
         c_out   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a_in;
         r_b     <= b_in;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= w_cin;
      end else if (r_state == ST_RUN) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_sum   <= w_sum_nx;
         r_carry <= w_fa_c;
         r_cnt   <= r_cnt + CNT_W'(1);
         if (w_last) begin
            sum_out <= w_sum_nx;
            c_out   <= w_fa_c;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed self-checking bench for serial_adder_seq (WIDTH=8); honours SERIAL_ADD_CIN_EN.
module tb_serial_adder_seq;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int unsigned n_pass;
   int unsigned n_total;

   serial_adder_seq #(.WIDTH(WIDTH)) u_dut (
      .clk_in   (clk),
      .rst_in   (rst),
      .start_in (start),
`ifdef SERIAL_ADD_CIN_EN
      .cin_in   (cin),
`endif
      .a_in     (a),
      .b_in     (b),
      .busy_out (busy),
      .done_out (done),
      .sum_out  (sum),
      .c_out    (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One addition from IDLE; optionally re-pulses start with other operands mid-RUN.
   task automatic run_add(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic [WIDTH-1:0] exp_s, input logic exp_c,
                          input bit repulse);
      int unsigned n;
      int unsigned nbusy;
      int unsigned ndone;
      bit          seen;
      @(negedge clk);
      a = av; b = bv; cin = cv; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = 8'hC3; b = 8'h7E; cin = 1'b0;
      check({tag, "_busy_acc"}, 32'(busy), 32'd1);
      nbusy = 1; n = 0; seen = 0;
      while (!seen && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (repulse && n == 3) begin
            start = 1'b1; a = 8'h11; b = 8'h22;
         end else begin
            start = 1'b0;
         end
         if (busy) nbusy++;
         if (done) seen = 1;
      end
      check({tag, "_latency"}, 32'(n), 32'(WIDTH));
      check({tag, "_sum"}, 32'(sum), 32'(exp_s));
      check({tag, "_cout"}, 32'(cout), 32'(exp_c));
      check({tag, "_busy_cycles"}, 32'(nbusy), 32'(WIDTH + 1));
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      ndone = 0;
      repeat (12) begin
         @(posedge clk);
         @(negedge clk);
         if (done) ndone++;
      end
      check({tag, "_no_extra_done"}, 32'(ndone), 32'd0);
      check({tag, "_sum_held"}, 32'(sum), 32'(exp_s));
   endtask

   initial begin
      int unsigned pulses;
      int unsigned first_k;
      int unsigned last_k;
      int unsigned gap_bad;
      int unsigned sum_bad;
      n_pass = 0; n_total = 0;
      rst = 1'b1; start = 1'b0; cin = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      rst = 1'b0;

      run_add("t5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
      run_add("tff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
      run_add("tffff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 0);
      run_add("trepulse", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1);

      // Abort 4 edges into RUN; reset must clear outputs without a clock.
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      #2 rst = 1'b0;
      run_add("tpost_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0);

      // Start held high: re-accepted every WIDTH+2 edges.
      @(negedge clk);
      a = 8'h01; b = 8'h01; start = 1'b1;
      pulses = 0; first_k = 0; last_k = 0; gap_bad = 0; sum_bad = 0;
      for (int unsigned k = 0; k < 30; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            if (pulses == 0) first_k = k;
            else if (k - last_k != WIDTH + 2) gap_bad++;
            if (sum !== 8'h02 || cout !== 1'b0) sum_bad++;
            last_k = k;
            pulses++;
         end
      end
      start = 1'b0;
      check("held_pulses", 32'(pulses), 32'd3);
      check("held_first", 32'(first_k), 32'(WIDTH));
      check("held_gap", 32'(gap_bad), 32'd0);
      check("held_sum", 32'(sum_bad), 32'd0);
      repeat (12) @(negedge clk);

`ifdef SERIAL_ADD_CIN_EN
      run_add("tcin", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0);
`else
      run_add("tcin", 8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
